// File: rtl/vram_loader.sv
// vram_loader -- copies WORDS consecutive words from a registered-output ROM
// into VRAM, one word per cycle, with a stall input that freezes all progress.
//
// Ports
//   clk, reset   : sole clock, synchronous active-high reset
//   start        : one-cycle run request, sampled only while idle
//   hold         : stall (active video); while high nothing advances
//   rom_ce       : ROM read enable; the ROM only updates rom_data when high
//   rom_addr     : ROM word address
//   rom_data     : ROM data, valid the cycle after rom_ce was high
//   vram_we      : VRAM write strobe
//   vram_addr    : VRAM write address
//   vram_wdata   : VRAM write data
//   busy         : from the cycle after start is accepted through the done cycle
//   done         : one-cycle completion pulse
//
// Optional feature (macro VRAM_LOADER_FILL_EN):
//   adds fill / fill_value inputs, latched with start. A fill run never
//   reads the ROM and writes fill_value to every address, with identical
//   hold/busy/done timing.

module vram_loader #(
  parameter int WORDS  = 2048,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
`ifdef VRAM_LOADER_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_value,
`endif
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counters carry one extra bit so that WORDS == 2**ADDR_W can be
  // represented as the terminal read count without wrapping to zero.
  localparam logic [ADDR_W:0] N_WORDS = (ADDR_W+1)'(WORDS);
  localparam logic [ADDR_W:0] LAST_WA = N_WORDS - (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W:0]   rd;       // next ROM address to read
  logic [ADDR_W:0]   wa;       // VRAM address of the word sitting in rom_data
  logic              wv;       // rom_data holds a word not yet written
  logic              fill_mode;
  logic [DATA_W-1:0] fill_val;

  logic rd_more;
  logic last_wr;
  logic advance;

  assign rd_more = (rd < N_WORDS);
  assign last_wr = wv && (wa == LAST_WA);
  // Progress happens only in COPY on an unstalled cycle.
  assign advance = (state == S_COPY) && !hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rd       <= '0;
      wa       <= '0;
      wv       <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      fill_val <= '0;
`ifdef VRAM_LOADER_FILL_EN
      fill_mode <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Accepted even with hold high; the run then waits in COPY.
            state <= S_COPY;
            busy  <= 1'b1;
            rd    <= '0;
            wa    <= '0;
            wv    <= 1'b0;
`ifdef VRAM_LOADER_FILL_EN
            fill_mode <= fill;
            fill_val  <= fill_value;
`endif
          end
        end

        S_COPY: begin
          if (advance) begin
            if (last_wr) begin
              // The final write happens this cycle; nothing left to read.
              state <= S_DONE;
              done  <= 1'b1;
              wv    <= 1'b0;
            end else if (rd_more) begin
              // Read rd now; its data lands in rom_data next cycle, where
              // it is written to VRAM at the same address.
              rd <= rd + ONE;
              wa <= rd;
              wv <= 1'b1;
            end else begin
              wv <= 1'b0;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          wv    <= 1'b0;
        end
      endcase
    end
  end

`ifndef VRAM_LOADER_FILL_EN
  assign fill_mode = 1'b0;
`endif

  // The strobes must drop in the very cycle hold rises: if rom_ce stayed
  // high the ROM would overwrite the pending word. They also drop while
  // reset is high so an aborted run issues no further writes.
  assign rom_ce     = advance && !reset && rd_more && !fill_mode;
  assign rom_addr   = rd[ADDR_W-1:0];
  assign vram_we    = (state == S_COPY) && wv && !hold && !reset;
  assign vram_addr  = wa[ADDR_W-1:0];
  assign vram_wdata = fill_mode ? fill_val : rom_data;

endmodule

// File: tb/tb_vram_loader.sv
// Bench for vram_loader: three instances (WORDS=8/ADDR_W=3, WORDS=1,
// WORDS=2048/ADDR_W=11) each backed by a registered ROM model. A reference
// model counts unstalled cycles since start: the k-th unstalled COPY cycle
// reads word k and writes word k-1; after WORDS+1 such cycles comes DONE.

module tb_vram_loader;

`ifdef VRAM_LOADER_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hold = 1'b0;
  logic [2:0] start = '0;
  logic       fill = 1'b0;
  logic [7:0] fill_value = '0;

  logic [7:0] rom_mem [0:2047];

  logic [2:0]       ce_v, we_v, busy_v, done_v;
  logic [2:0][10:0] ra_v, va_v;
  logic [2:0][7:0]  wd_v, rdat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign ra_v[0][10:3] = '0;
  assign va_v[0][10:3] = '0;

  vram_loader #(.WORDS(8), .ADDR_W(3), .DATA_W(8)) u_w8 (
    .clk(clk), .reset(reset), .start(start[0]), .hold(hold),
`ifdef VRAM_LOADER_FILL_EN
    .fill(fill), .fill_value(fill_value),
`endif
    .rom_ce(ce_v[0]), .rom_addr(ra_v[0][2:0]), .rom_data(rdat[0]),
    .vram_we(we_v[0]), .vram_addr(va_v[0][2:0]), .vram_wdata(wd_v[0]),
    .busy(busy_v[0]), .done(done_v[0]));

  vram_loader #(.WORDS(1), .ADDR_W(11), .DATA_W(8)) u_w1 (
    .clk(clk), .reset(reset), .start(start[1]), .hold(hold),
`ifdef VRAM_LOADER_FILL_EN
    .fill(fill), .fill_value(fill_value),
`endif
    .rom_ce(ce_v[1]), .rom_addr(ra_v[1]), .rom_data(rdat[1]),
    .vram_we(we_v[1]), .vram_addr(va_v[1]), .vram_wdata(wd_v[1]),
    .busy(busy_v[1]), .done(done_v[1]));

  vram_loader #(.WORDS(2048), .ADDR_W(11), .DATA_W(8)) u_w2k (
    .clk(clk), .reset(reset), .start(start[2]), .hold(hold),
`ifdef VRAM_LOADER_FILL_EN
    .fill(fill), .fill_value(fill_value),
`endif
    .rom_ce(ce_v[2]), .rom_addr(ra_v[2]), .rom_data(rdat[2]),
    .vram_we(we_v[2]), .vram_addr(va_v[2]), .vram_wdata(wd_v[2]),
    .busy(busy_v[2]), .done(done_v[2]));

  // Registered ROMs: data only updates when the enable is high.
  always @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (ce_v[k]) rdat[k] <= rom_mem[ra_v[k]];

  function automatic int words_of(input int s);
    return (s == 0) ? 8 : (s == 1) ? 1 : 2048;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state for the selected instance.
  int         sel = 0;
  int         m_ph = -1;   // -1 unknown, 0 idle, 1 running, 2 done
  int         m_cnt = 0;   // unstalled COPY cycles so far
  bit         m_fill = 0;
  logic [7:0] m_val = '0;
  int         wr_cnt, done_cnt, busy_cnt;
  logic [10:0] last_wa;

  task automatic tick();
    int w;
    logic e_ce, e_we;
    logic [10:0] e_ra, e_va;
    logic [7:0] e_wd;
    @(negedge clk);
    w = words_of(sel);
    if (m_ph >= 0) begin
      e_ce = 0; e_we = 0; e_ra = '0; e_va = '0; e_wd = '0;
      if (m_ph == 1 && !hold && !reset) begin
        if (m_cnt < w && !m_fill) begin e_ce = 1; e_ra = 11'(m_cnt); end
        if (m_cnt >= 1 && m_cnt <= w) begin
          e_we = 1;
          e_va = 11'(m_cnt - 1);
          e_wd = m_fill ? m_val : rom_mem[m_cnt - 1];
        end
      end
      chk("rom_ce", 32'(ce_v[sel]), 32'(e_ce));
      if (e_ce) chk("rom_addr", 32'(ra_v[sel]), 32'(e_ra));
      chk("vram_we", 32'(we_v[sel]), 32'(e_we));
      if (e_we) begin
        chk("vram_addr", 32'(va_v[sel]), 32'(e_va));
        chk("vram_wdata", 32'(wd_v[sel]), 32'(e_wd));
      end
      chk("busy", 32'(busy_v[sel]), 32'(m_ph != 0));
      chk("done", 32'(done_v[sel]), 32'(m_ph == 2));
    end
    if (we_v[sel]) begin wr_cnt++; last_wa = va_v[sel]; end
    if (done_v[sel]) done_cnt++;
    if (busy_v[sel]) busy_cnt++;
    if (reset) m_ph = 0;
    else case (m_ph)
      0: if (start[sel]) begin
           m_ph = 1; m_cnt = 0;
           m_fill = FILL_ON && fill;
           m_val = fill_value;
         end
      1: if (!hold) begin
           m_cnt++;
           if (m_cnt == w + 1) m_ph = 2;
         end
      2: m_ph = 0;
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  // mode: 0 plain, 1 hold 3 cycles after 4th write, 2 random hold,
  //       3 start re-pulsed mid-run and in DONE, 4 reset after 5th write
  task automatic run(input int s, input int mode, input logic f, input logic [7:0] fv);
    int n, hc;
    bit rdone;
    sel = s; wr_cnt = 0; done_cnt = 0; busy_cnt = 0; last_wa = '1;
    hc = 0; rdone = 0;
    fill = f; fill_value = fv;
    start[s] = 1'b1;
    hold = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    start[s] = 1'b0;
    fill = 1'($urandom_range(0, 1));
    fill_value = 8'($urandom);
    n = 0;
    while (m_ph != 0 && n < 6000) begin
      hold = 0; reset = 0; start[s] = 0;
      case (mode)
        1: if (wr_cnt == 4 && hc < 3) begin hold = 1; hc++; end
        2: hold = ($urandom_range(0, 3) == 0);
        3: start[s] = (m_ph == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        4: if (wr_cnt == 5 && !rdone) begin reset = 1; rdone = 1; end
        default: ;
      endcase
      tick();
      n++;
    end
    hold = 0; reset = 0; start[s] = 0; fill = 0;
    chk("run_timeout", 32'(n < 6000), 32'd1);
    if (mode == 4) begin
      chk("rst_writes", 32'(wr_cnt), 32'd5);
      chk("rst_done", 32'(done_cnt), 32'd0);
      chk("rst_busy", 32'(busy_v[s]), 32'd0);
      chk("rst_rom_addr", 32'(ra_v[s]), 32'd0);
      chk("rst_vram_addr", 32'(va_v[s]), 32'd0);
    end else begin
      chk("n_writes", 32'(wr_cnt), 32'(words_of(s)));
      chk("n_done", 32'(done_cnt), 32'd1);
      chk("last_addr", 32'(last_wa), 32'(words_of(s) - 1));
      if (mode == 0) chk("busy_len", 32'(busy_cnt), 32'(words_of(s) + 2));
    end
    tick();
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'(i + 'h10);
    reset = 1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("reset_rom_addr", 32'(ra_v[k]), 32'd0);
      chk("reset_vram_addr", 32'(va_v[k]), 32'd0);
      chk("reset_busy", 32'(busy_v[k]), 32'd0);
      chk("reset_done", 32'(done_v[k]), 32'd0);
    end
    reset = 0;
    tick();

    run(0, 0, 0, 0);
    run(0, 1, 0, 0);
    run(0, 3, 0, 0);
    run(0, 4, 0, 0);
    run(0, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
      run(0, 2, 0, 0);
    end
    run(1, 0, 0, 0);
    run(1, 2, 0, 0);
    run(1, 3, 0, 0);
    run(2, 0, 0, 0);
    run(2, 2, 0, 0);
`ifdef VRAM_LOADER_FILL_EN
    run(0, 0, 1, 8'hA5);
    run(0, 2, 1, 8'($urandom));
    run(1, 0, 1, 8'h3C);
    run(0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
